// File: rtl/int2float_pipe.sv
// Pipelined integer-to-float converter with round-to-nearest-even and an inexact flag.
// Three register stages (sign/magnitude, normalise, round/pack) sharing one global advance.
module int2float_pipe #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned MAN_WIDTH = 23
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_WIDTH-1:0]            in_data,
  input  logic                           in_signed,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   out_data,
  output logic                           out_inexact
);

  localparam int unsigned BIAS = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int unsigned PW   = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int unsigned FW   = MAN_WIDTH + 1;
  localparam int unsigned EW   = IN_WIDTH + MAN_WIDTH + 1;

  // IN_WIDTH <= BIAS keeps p + BIAS + carry inside the exponent field.
  if (IN_WIDTH < 2 || IN_WIDTH > BIAS) begin : gen_param_check
    $error("int2float_pipe: IN_WIDTH must be in [2, BIAS]");
  end

  logic adv;

  // Stage 1: sign and magnitude
  logic                 s1_valid_q;
  logic                 s1_sign_q, s1_sign_d;
  logic [IN_WIDTH-1:0]  s1_mag_q, s1_mag_d;

  // Stage 2: normalised magnitude, leading-one index
  logic                 s2_valid_q;
  logic                 s2_sign_q;
  logic                 s2_zero_q, s2_zero_d;
  logic [PW-1:0]        s2_p_q, s2_p_d;
  logic [IN_WIDTH-2:0]  s2_low_q, s2_low_d;
  logic [IN_WIDTH-1:0]  s2_norm;

  // Stage 3: packed result
  logic                          out_valid_q;
  logic [EXP_WIDTH+MAN_WIDTH:0]  out_data_q, out_data_d;
  logic                          out_inexact_q, out_inexact_d;

  logic [EW-1:0]        ext;
  logic [MAN_WIDTH-1:0] frac;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [FW-1:0]        frac_inc;
  logic [EXP_WIDTH-1:0] exp_field;

  assign adv      = !out_valid_q | out_ready;
  assign in_ready = rst_n & adv;

  always_comb begin
    s1_sign_d = in_signed & in_data[IN_WIDTH-1];
    s1_mag_d  = s1_sign_d ? (~in_data + IN_WIDTH'(1)) : in_data;
  end

  always_comb begin
    s2_p_d = '0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      if (s1_mag_q[i]) s2_p_d = PW'(i);
    end
    s2_norm   = s1_mag_q << (PW'(IN_WIDTH - 1) - s2_p_d);
    // After normalisation the MSB is set unless the magnitude was zero.
    s2_zero_d = ~s2_norm[IN_WIDTH-1];
    s2_low_d  = s2_norm[IN_WIDTH-2:0];
  end

  always_comb begin
    // Bits below the leading one, padded so frac/guard always exist.
    ext       = {s2_low_q, {(MAN_WIDTH + 2){1'b0}}};
    frac      = ext[EW-1 -: MAN_WIDTH];
    guard     = ext[IN_WIDTH];
    sticky    = |ext[IN_WIDTH-1:0];
    round_up  = guard & (sticky | frac[0]);
    frac_inc  = {1'b0, frac} + FW'(round_up);
    exp_field = EXP_WIDTH'(s2_p_q) + EXP_WIDTH'(BIAS) + EXP_WIDTH'(frac_inc[MAN_WIDTH]);
    if (s2_zero_q) begin
      out_data_d    = '0;
      out_inexact_d = 1'b0;
    end else begin
      out_data_d    = {s2_sign_q, exp_field, frac_inc[MAN_WIDTH-1:0]};
      out_inexact_d = guard | sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_mag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_zero_q     <= 1'b1;
      s2_p_q        <= '0;
      s2_low_q      <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q    <= in_valid;
      s1_sign_q     <= s1_sign_d;
      s1_mag_q      <= s1_mag_d;
      s2_valid_q    <= s1_valid_q;
      s2_sign_q     <= s1_sign_q;
      s2_zero_q     <= s2_zero_d;
      s2_p_q        <= s2_p_d;
      s2_low_q      <= s2_low_d;
      out_valid_q   <= s2_valid_q;
      out_data_q    <= out_data_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

endmodule
